pipeline_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges stall requests from the IF, ID, EX and MEM stages into per-register stall and flush vectors for PC, IF2ID, ID2EX, EX2MEM and MEM2WB.
- Converts MEM-stage exceptions and ERET into a pipeline flush plus a PC redirect.
- Runs a small FSM that defers the redirect while an instruction fetch is outstanding.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/stall_merge.sv | 33 +++
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: exception codes,
// pipeline-register indices and the controller state encoding.
package pipe_pkg;

   localparam logic [31:0] EXC_INT  = 32'h1;
   localparam logic [31:0] EXC_ADEL = 32'h4;
   localparam logic [31:0] EXC_ADES = 32'h5;
   localparam logic [31:0] EXC_SYS  = 32'h8;
   localparam logic [31:0] EXC_BP   = 32'h9;
   localparam logic [31:0] EXC_RI   = 32'ha;
   localparam logic [31:0] EXC_OV   = 32'hc;
   localparam logic [31:0] EXC_ERET = 32'he;

   localparam int PC_IDX     = 0;
   localparam int IF2ID_IDX  = 1;
   localparam int ID2EX_IDX  = 2;
   localparam int EX2MEM_IDX = 3;
   localparam int MEM2WB_IDX = 4;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } ctrl_state_t;

endpackage

// File: rtl/stall_merge.sv
// Combinational priority merge of stage stall requests: the most downstream
// requester holds itself and everything upstream and bubbles the next register.
module stall_merge
   import pipe_pkg::*;
#(
   parameter int NREG = 5
) (
   input  logic            if_req_i,
   input  logic            id_req_i,
   input  logic            ex_req_i,
   input  logic            mem_req_i,
   output logic [NREG-1:0] stall_o,
   output logic [NREG-1:0] flush_o
);

   int win;

   always_comb begin
      win     = -1;
      stall_o = '0;
      flush_o = '0;
      // Later assignments override earlier ones, so the downstream stage wins.
      if (if_req_i)  win = PC_IDX;
      if (id_req_i)  win = IF2ID_IDX;
      if (ex_req_i)  win = ID2EX_IDX;
      if (mem_req_i) win = EX2MEM_IDX;
      for (int k = 0; k < NREG; k++) begin
         stall_o[k] = (k <= win);
         flush_o[k] = (win >= 0) && (k == win + 1);
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with exception/ERET redirect.
// Optional performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter int          NREG       = 5
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            if_stall_req_i,
   input  logic            id_stall_req_i,
   input  logic            ex_stall_req_i,
   input  logic            mem_stall_req_i,
   input  logic            if_busy_i,
   input  logic [31:0]     exc_type_i,
   input  logic [31:0]     cp0_epc_i,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0]     perf_if_o,
   output logic [31:0]     perf_id_o,
   output logic [31:0]     perf_ex_o,
   output logic [31:0]     perf_mem_o,
   output logic [31:0]     perf_exc_o,
`endif
   output logic [NREG-1:0] stall_o,
   output logic [NREG-1:0] flush_o,
   output logic            pc_load_o,
   output logic [31:0]     new_pc_o,
   output logic            busy_o
);

   ctrl_state_t     state_q, state_d;
   logic [31:0]     target_q, target_d;
   logic [31:0]     exc_target;
   logic [NREG-1:0] merge_stall, merge_flush;

   stall_merge #(.NREG(NREG)) u_stall_merge (
      .if_req_i  (if_stall_req_i),
      .id_req_i  (id_stall_req_i),
      .ex_req_i  (ex_stall_req_i),
      .mem_req_i (mem_stall_req_i),
      .stall_o   (merge_stall),
      .flush_o   (merge_flush)
   );

   assign exc_target = (exc_type_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= RUN;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      stall_o   = '0;
      flush_o   = '0;
      pc_load_o = 1'b0;
      new_pc_o  = '0;
      busy_o    = 1'b0;
      case (state_q)
         RUN: begin
            if (exc_type_i != '0) begin
               flush_o         = '1;
               flush_o[PC_IDX] = 1'b0;
               if (!if_busy_i) begin
                  pc_load_o = 1'b1;
                  new_pc_o  = exc_target;
               end else begin
                  // Redirecting now would let the in-flight fetch land on the new path.
                  target_d = exc_target;
                  state_d  = DRAIN;
               end
            end else begin
               stall_o = merge_stall;
               flush_o = merge_flush;
            end
         end
         DRAIN: begin
            busy_o             = 1'b1;
            stall_o[PC_IDX]    = 1'b1;
            flush_o[IF2ID_IDX] = 1'b1;
            if (!if_busy_i) begin
               pc_load_o = 1'b1;
               new_pc_o  = target_q;
               state_d   = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

`ifdef PIPE_CTRL_PERF_EN
   logic        run_idle, exc_acc;
   logic [31:0] perf_if_q, perf_id_q, perf_ex_q, perf_mem_q, perf_exc_q;

   assign run_idle = (state_q == RUN) && (exc_type_i == '0);
   assign exc_acc  = (state_q == RUN) && (exc_type_i != '0);

   // The single set flush bit of the merge identifies the winning source.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         perf_if_q  <= '0;
         perf_id_q  <= '0;
         perf_ex_q  <= '0;
         perf_mem_q <= '0;
         perf_exc_q <= '0;
      end else begin
         if (run_idle && merge_flush[IF2ID_IDX])  perf_if_q  <= perf_if_q + 32'd1;
         if (run_idle && merge_flush[ID2EX_IDX])  perf_id_q  <= perf_id_q + 32'd1;
         if (run_idle && merge_flush[EX2MEM_IDX]) perf_ex_q  <= perf_ex_q + 32'd1;
         if (run_idle && merge_flush[MEM2WB_IDX]) perf_mem_q <= perf_mem_q + 32'd1;
         if (exc_acc)                             perf_exc_q <= perf_exc_q + 32'd1;
      end
   end

   assign perf_if_o  = perf_if_q;
   assign perf_id_o  = perf_id_q;
   assign perf_ex_o  = perf_ex_q;
   assign perf_mem_o = perf_mem_q;
   assign perf_exc_o = perf_exc_q;
`endif

endmodule
